// File: rtl/pcm_i2s_tx.sv
// PCM sample FIFO feeding a stereo I2S serialiser (Mp3Decode write port -> audio DAC).
// Define PCM_I2S_LJ_EN for left-justified output (no one-bit data delay).
module pcm_i2s_tx #(
  parameter int DEPTH_LOG2 = 6,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic                  Winc,
  input  logic [31:0]           Wdata,
  output logic                  Wfull,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  I2s_bclk,
  output logic                  I2s_lrck,
  output logic                  I2s_sdata,
  output logic                  Underrun,
  output logic                  Overflow
);
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
`ifdef PCM_I2S_LJ_EN
  localparam logic [4:0] LOAD_SLOT = 5'd0;
`else
  localparam logic [4:0] LOAD_SLOT = 5'd1;
`endif

  typedef enum logic [2:0] {IDLE, CHK, POPL, POPR, RUN} state_t;

  state_t                state_q, state_d;
  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic                  wfull_q, wfull_d, overflow_q, overflow_d, underrun_q, underrun_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic [4:0]            slot_q, slot_d, bit_idx;
  logic [31:0]           frame_q, frame_d;
`ifndef PCM_I2S_LJ_EN
  logic                  first_q, first_d;
`endif
  logic                  wr_en, pop, running, fall_evt;
  logic                  unused_wdata_hi;

  assign unused_wdata_hi = ^Wdata[31:16];

  always_comb begin
    wr_en    = Winc && !wfull_q;
    running  = Enable && (state_q != IDLE);
    fall_evt = running && bclk_q && (div_q == DIV_LAST);
    pop      = Enable && ((state_q == POPL) || (state_q == POPR));

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_en) count_d = count_q - 1'b1;
    // Full flag looks at the post-update count so it is valid for the next cycle's write.
    wfull_d    = (count_d == LW'(DEPTH));
    overflow_d = overflow_q | (Winc & wfull_q);

    div_d  = '0;
    bclk_d = 1'b0;
    slot_d = '0;
    lrck_d = 1'b0;
    if (running) begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      bclk_d = (div_q == DIV_LAST) ? ~bclk_q : bclk_q;
      slot_d = fall_evt ? slot_q + 1'b1 : slot_q;
      lrck_d = fall_evt ? slot_d[4] : lrck_q;
    end

    state_d    = state_q;
    frame_d    = frame_q;
    underrun_d = underrun_q;
`ifndef PCM_I2S_LJ_EN
    first_d    = first_q;
`endif
    if (!Enable) begin
      state_d = IDLE;
      frame_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_d = '0;
`ifdef PCM_I2S_LJ_EN
          state_d = RUN;
`else
          state_d = CHK;
          first_d = 1'b1;
`endif
        end
        // Pairs only: a lone leftover sample waits for its partner rather than being split.
        CHK: begin
          if (count_q >= LW'(2)) begin
            state_d = POPL;
          end else begin
            frame_d    = '0;
            underrun_d = 1'b1;
            state_d    = RUN;
          end
        end
        POPL: begin
          frame_d[31:16] = mem_q[rd_ptr_q];
          state_d        = POPR;
        end
        POPR: begin
          frame_d[15:0] = mem_q[rd_ptr_q];
          state_d       = RUN;
        end
        RUN: begin
          if (fall_evt && (slot_d == LOAD_SLOT)) begin
`ifdef PCM_I2S_LJ_EN
            state_d = CHK;
`else
            if (first_q) first_d = 1'b0;
            else         state_d = CHK;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    sdata_d = 1'b0;
`ifdef PCM_I2S_LJ_EN
    bit_idx = 5'd31 - slot_d;
    if (running) sdata_d = frame_d[bit_idx];
`else
    // Slot 0 keeps the previous frame's last bit even while the next frame loads.
    bit_idx = 5'd0 - slot_d;
    if (running) begin
      if (slot_d == 5'd0) sdata_d = fall_evt ? frame_q[0] : sdata_q;
      else                sdata_d = frame_d[bit_idx];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wfull_q    <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      slot_q     <= '0;
      frame_q    <= '0;
`ifndef PCM_I2S_LJ_EN
      first_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wfull_q    <= wfull_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
`ifndef PCM_I2S_LJ_EN
      first_q    <= first_d;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= Wdata[15:0];
  end

  assign Wfull     = wfull_q;
  assign Level     = count_q;
  assign I2s_bclk  = bclk_q;
  assign I2s_lrck  = lrck_q;
  assign I2s_sdata = sdata_q;
  assign Underrun  = underrun_q;
  assign Overflow  = overflow_q;
endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: directed reset/full/abort cases plus random streaming, checked
// against a sample-queue model that rebuilds each I2S frame word from bits seen at BCLK rises.
module tb_pcm_i2s_tx;
  localparam int DL2   = 2;
  localparam int DIV   = 4;
  localparam int DEPTH = 1 << DL2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Enable = 1'b0;
  logic          Winc = 1'b0;
  logic [31:0]   Wdata = '0;
  logic          Wfull;
  logic [DL2:0]  Level;
  logic          I2s_bclk, I2s_lrck, I2s_sdata, Underrun, Overflow;

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   mdl_q[$];
  logic          mdl_underrun = 1'b0;
  logic          mdl_overflow = 1'b0;
  logic          fresh = 1'b0;
  logic [31:0]   prev_f = '0, cur_f = '0, got_f = '0, lr_pat = '0;

  pcm_i2s_tx #(.DEPTH_LOG2(DL2), .BCLK_DIV(DIV)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Winc(Winc), .Wdata(Wdata),
    .Wfull(Wfull), .Level(Level), .I2s_bclk(I2s_bclk), .I2s_lrck(I2s_lrck),
    .I2s_sdata(I2s_sdata), .Underrun(Underrun), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic finishSim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic nextClk();
    @(posedge Clk);
    #1;
  endtask

  // One write cycle; the model drops the word when it already holds a full FIFO.
  task automatic applyStimulus(input logic [15:0] sample);
    Winc  = 1'b1;
    Wdata = {16'($urandom), sample};
    if (mdl_q.size() == DEPTH) mdl_overflow = 1'b1;
    else                       mdl_q.push_back(sample);
    nextClk();
    Winc = 1'b0;
  endtask

  task automatic doReset();
    Rst = 1'b1;
    Enable = 1'b0;
    Winc = 1'b0;
    repeat (3) nextClk();
    Rst = 1'b0;
    mdl_q.delete();
    mdl_underrun = 1'b0;
    mdl_overflow = 1'b0;
  endtask

  task automatic modelLoad(output logic [31:0] f);
    if (mdl_q.size() >= 2) begin
      f[31:16] = mdl_q.pop_front();
      f[15:0]  = mdl_q.pop_front();
    end else begin
      f = '0;
      mdl_underrun = 1'b1;
    end
  endtask

  task automatic waitBclk(input logic lvl);
    int n = 0;
    while (I2s_bclk !== lvl) begin
      nextClk();
      n++;
      if (n > 4 * DIV) begin
        checkOutput("bclk_timeout", 32'(I2s_bclk), 32'(lvl));
        finishSim();
      end
    end
  endtask

  task automatic captureSlot(output logic b, output logic lr);
    waitBclk(1'b1);
    b  = I2s_sdata;
    lr = I2s_lrck;
    waitBclk(1'b0);
  endtask

  task automatic startStream();
    Enable = 1'b1;
    prev_f = '0;
    fresh  = 1'b1;
    modelLoad(cur_f);
  endtask

  // Captures whole frames from slot 0; abort_slot >= 0 drops Enable at that slot of the last frame.
  task automatic runFrames(input int nframes, input int max_wr, input int abort_slot);
    logic b, lr;
    int   n;
    for (int f = 0; f < nframes; f++) begin
      for (int s = 0; s < 32; s++) begin
        if (f == nframes - 1 && s == abort_slot) begin
          checkOutput("pre_abort_sdata", 32'(I2s_sdata), 32'(cur_f[32-s]));
          Enable = 1'b0;
          nextClk();
          checkOutput("abort_bclk", 32'(I2s_bclk), 32'd0);
          checkOutput("abort_lrck", 32'(I2s_lrck), 32'd0);
          checkOutput("abort_sdata", 32'(I2s_sdata), 32'd0);
          return;
        end
        if (s == 1) begin
          if (fresh) fresh = 1'b0;
          else       modelLoad(cur_f);
        end
        captureSlot(b, lr);
        lr_pat[s] = lr;
        if (s == 0) begin
          got_f[0] = b;
          if (fresh) checkOutput("slot0_start", 32'(b), 32'(prev_f[0]));
          else       checkOutput("frame_word", got_f, prev_f);
        end else begin
          got_f[32-s] = b;
        end
        if (s >= 4 && s <= 7) begin
          n = $urandom_range(max_wr, 0);
          for (int k = 0; k < n; k++) applyStimulus(16'($urandom));
        end
        if (s == 10) begin
          checkOutput("level", 32'(Level), mdl_q.size());
          checkOutput("wfull", 32'(Wfull), 32'(mdl_q.size() == DEPTH));
          checkOutput("underrun", 32'(Underrun), 32'(mdl_underrun));
          checkOutput("overflow", 32'(Overflow), 32'(mdl_overflow));
        end
      end
      checkOutput("lrck_pattern", lr_pat, 32'hFFFF_0000);
      prev_f = cur_f;
    end
  endtask

  task automatic closeStream();
    logic b, lr;
    captureSlot(b, lr);
    got_f[0] = b;
    checkOutput("frame_word_last", got_f, prev_f);
    Enable = 1'b0;
    nextClk();
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got time limit reached, expected completion");
    finishSim();
  end

  initial begin
    logic [15:0] l1;
    int          nf;

    $display("[TB] reset");
    repeat (3) nextClk();
    checkOutput("rst_level", 32'(Level), 32'd0);
    checkOutput("rst_wfull", 32'(Wfull), 32'd0);
    checkOutput("rst_bclk", 32'(I2s_bclk), 32'd0);
    checkOutput("rst_lrck", 32'(I2s_lrck), 32'd0);
    checkOutput("rst_sdata", 32'(I2s_sdata), 32'd0);
    checkOutput("rst_underrun", 32'(Underrun), 32'd0);
    checkOutput("rst_overflow", 32'(Overflow), 32'd0);
    doReset();

    $display("[TB] basic frame");
    applyStimulus(16'h8001);
    applyStimulus(16'h7FFE);
    startStream();
    runFrames(2, 0, -1);
    closeStream();

    $display("[TB] single-sample underrun");
    doReset();
    applyStimulus(16'($urandom));
    startStream();
    runFrames(1, 0, -1);
    closeStream();

    $display("[TB] full and overflow");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'($urandom));
      checkOutput("fill_wfull", 32'(Wfull), 32'(i >= 3));
      checkOutput("fill_level", 32'(Level), (i >= 3) ? 32'd4 : 32'(i + 1));
    end
    checkOutput("fill_overflow", 32'(Overflow), 32'd1);

    $display("[TB] write coincident with left pop");
    startStream();
    nextClk();
    nextClk();
    Winc  = 1'b1;
    Wdata = $urandom;
    nextClk();
    Winc = 1'b0;
    checkOutput("pop_wr_level", 32'(Level), 32'd3);
    checkOutput("pop_wr_wfull", 32'(Wfull), 32'd0);
    nextClk();
    checkOutput("pop_wr_level2", 32'(Level), 32'd2);
    runFrames(3, 0, -1);
    closeStream();

    $display("[TB] abort and restart");
    doReset();
    l1 = 16'($urandom) | 16'h0080;
    applyStimulus(l1);
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom));
    startStream();
    runFrames(1, 0, 9);
    checkOutput("abort_level", 32'(Level), mdl_q.size());
    checkOutput("abort_underrun", 32'(Underrun), 32'd0);
    startStream();
    runFrames(2, 0, -1);
    closeStream();

    $display("[TB] random streaming");
    doReset();
    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(4, 1);
      for (int k = $urandom_range(4, 0); k > 0; k--) applyStimulus(16'($urandom));
      startStream();
      if (r % 2 == 1) begin
        runFrames(nf, 1, $urandom_range(30, 2));
        nextClk();
      end else begin
        runFrames(nf, 1, -1);
        closeStream();
      end
    end

    finishSim();
  end
endmodule
